// File: rtl/mem_island_port_mux.sv
// mem_island_port_mux: merges NumIn in-order mem-protocol request ports onto a
// single memory-island port.
// - Arbitration is round-robin. Once a request has been offered and stalled,
//   the arbiter locks onto that port, so the fields it presents stay stable.
// - A credit counter bounds the number of granted-but-unanswered requests.
// - An ID FIFO routes each in-order response back to the port it came from.
// Optional build macro: MEM_ISLAND_PORT_MUX_RSP_SPILL_EN registers the response
// fan-out, adding one cycle of response latency.
//
// Handshake: a request transfers in a cycle where out_req_o and out_gnt_i are
// both high, and then in_gnt_o pulses for the selected port in that same cycle.
// Each upstream port must hold in_req_i and its request fields until granted.
// The island returns exactly one out_rvalid_i per transferred request, in order.
module mem_island_port_mux #(
  parameter int NumIn          = 4,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 4,
  parameter int StrbWidth      = DataWidth / 8,
  parameter int IdxWidth       = $clog2(NumIn)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NumIn-1:0]                    in_req_i,
  output logic [NumIn-1:0]                    in_gnt_o,
  input  logic [NumIn-1:0][AddrWidth-1:0]     in_addr_i,
  input  logic [NumIn-1:0]                    in_we_i,
  input  logic [NumIn-1:0][DataWidth-1:0]     in_wdata_i,
  input  logic [NumIn-1:0][StrbWidth-1:0]     in_strb_i,
  output logic [NumIn-1:0]                    in_rvalid_o,
  output logic [NumIn-1:0][DataWidth-1:0]     in_rdata_o,
  output logic                                out_req_o,
  input  logic                                out_gnt_i,
  output logic [AddrWidth-1:0]                out_addr_o,
  output logic                                out_we_o,
  output logic [DataWidth-1:0]                out_wdata_o,
  output logic [StrbWidth-1:0]                out_strb_o,
  input  logic                                out_rvalid_i,
  input  logic [DataWidth-1:0]                out_rdata_i,
  output logic                                err_o,
  output logic                                dbg_locked_o
);

  localparam int CntWidth = $clog2(MaxOutstanding + 1);
  localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } arb_state_e;

  arb_state_e            state_q, state_d;
  logic [IdxWidth-1:0]   lock_idx_q, lock_idx_d;
  logic [IdxWidth-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxWidth-1:0]   rr_sel;
  logic                  rr_found;
  logic [IdxWidth:0]     cand_sum;
  logic [IdxWidth-1:0]   sel;
  logic [IdxWidth-1:0]   sel_inc;
  logic                  req_ok;
  logic                  avail;
  logic                  out_req;
  logic                  hs;
  logic                  lock_drop;

  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IdxWidth-1:0]   fifo_q [MaxOutstanding];
  logic [IdxWidth-1:0]   head;
  logic                  pop;
  logic                  rsp_err;
  logic                  err_q, err_d;

  // Round-robin search: first requesting port at or after rr_ptr_q, wrapping.
  always_comb begin
    rr_sel   = rr_ptr_q;
    rr_found = 1'b0;
    cand_sum = '0;
    for (int i = 0; i < NumIn; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IdxWidth+1)'(i);
      if (cand_sum >= (IdxWidth+1)'(NumIn)) begin
        cand_sum = cand_sum - (IdxWidth+1)'(NumIn);
      end
      if (!rr_found && in_req_i[cand_sum[IdxWidth-1:0]]) begin
        rr_sel   = cand_sum[IdxWidth-1:0];
        rr_found = 1'b1;
      end
    end
  end

  // A locked port must keep its own request up. Other ports' requests must
  // not wake the island while that port's request is stable.
  assign sel     = (state_q == ST_LOCKED) ? lock_idx_q : rr_sel;
  assign req_ok  = (state_q == ST_LOCKED) ? in_req_i[lock_idx_q] : (|in_req_i);
  // The credit check uses the registered count only, so there is no
  // combinational out_rvalid_i -> out_req_o path.
  assign avail   = (cnt_q < CntWidth'(MaxOutstanding));
  assign out_req = ~rst_i & avail & req_ok;
  assign hs      = out_req & out_gnt_i;
  assign sel_inc = (sel == IdxWidth'(NumIn - 1)) ? '0 : sel + IdxWidth'(1);

  // Request fields are muxed from the selected port; they are zero while in reset.
  always_comb begin
    out_req_o   = out_req;
    in_gnt_o    = hs ? (NumIn'(1) << sel) : '0;
    out_addr_o  = rst_i ? '0 : in_addr_i[sel];
    out_we_o    = rst_i ? 1'b0 : in_we_i[sel];
    out_wdata_o = rst_i ? '0 : in_wdata_i[sel];
    out_strb_o  = rst_i ? '0 : in_strb_i[sel];
  end

  // Arbiter next state: a handshake always unlocks and advances the pointer.
  // A stalled offer locks. A dropped locked request unlocks and flags an error.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    lock_drop  = 1'b0;
    if (hs) begin
      state_d  = ST_UNLOCKED;
      rr_ptr_d = sel_inc;
    end else if (state_q == ST_LOCKED) begin
      if (!in_req_i[lock_idx_q]) begin
        state_d   = ST_UNLOCKED;
        lock_drop = 1'b1;
      end
    end else if (out_req) begin
      state_d    = ST_LOCKED;
      lock_idx_d = sel;
    end
  end

  // Arbiter state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_UNLOCKED;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign dbg_locked_o = (state_q == ST_LOCKED);

  // The FIFO occupancy equals cnt_q. A response with nothing outstanding is
  // dropped and flagged as an error.
  assign head    = fifo_q[rd_ptr_q];
  assign pop     = out_rvalid_i & (cnt_q != '0) & ~rst_i;
  assign rsp_err = out_rvalid_i & (cnt_q == '0);

  // Credit count, ID FIFO pointers and the sticky error: next-state logic.
  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (hs && !pop) begin
      cnt_d = cnt_q + CntWidth'(1);
    end else if (pop && !hs) begin
      cnt_d = cnt_q - CntWidth'(1);
    end
    if (hs) begin
      wr_ptr_d = (wr_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrWidth'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
    end
    err_d = err_q | rsp_err | lock_drop;
  end

  // Credit count, ID FIFO pointers and the sticky error: registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  assign err_o = err_q;

  // ID FIFO storage; the pointers and count above make reset unnecessary here.
  always_ff @(posedge clk_i) begin
    if (hs) begin
      fifo_q[wr_ptr_q] <= sel;
    end
  end

`ifdef MEM_ISLAND_PORT_MUX_RSP_SPILL_EN
  logic                 rsp_valid_q;
  logic [IdxWidth-1:0]  rsp_idx_q;
  logic [DataWidth-1:0] rsp_data_q;

  // Response spill stage: registers the popped index and data before fan-out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= pop;
      rsp_idx_q   <= head;
      rsp_data_q  <= out_rdata_i;
    end
  end

  assign in_rvalid_o = rsp_valid_q ? (NumIn'(1) << rsp_idx_q) : '0;
  assign in_rdata_o  = {NumIn{rsp_data_q}};
`else
  // Combinational response fan-out: the FIFO head selects which port sees rvalid.
  assign in_rvalid_o = pop ? (NumIn'(1) << head) : '0;
  assign in_rdata_o  = rst_i ? '0 : {NumIn{out_rdata_i}};
`endif

endmodule

// File: tb/tb_mem_island_port_mux.sv
// Testbench for mem_island_port_mux (default build, 4 ports, 4 credits).
module tb_mem_island_port_mux;

  logic              clk_i;
  logic              rst_i;
  logic [3:0]        in_req_i;
  logic [3:0]        in_gnt_o;
  logic [3:0][31:0]  in_addr_i;
  logic [3:0]        in_we_i;
  logic [3:0][63:0]  in_wdata_i;
  logic [3:0][7:0]   in_strb_i;
  logic [3:0]        in_rvalid_o;
  logic [3:0][63:0]  in_rdata_o;
  logic              out_req_o;
  logic              out_gnt_i;
  logic [31:0]       out_addr_o;
  logic              out_we_o;
  logic [63:0]       out_wdata_o;
  logic [7:0]        out_strb_o;
  logic              out_rvalid_i;
  logic [63:0]       out_rdata_i;
  logic              err_o;
  logic              dbg_locked_o;

  int n_tests;
  int n_fail;

  // Scoreboard: expected grant order, and expected response destinations.
  logic [1:0] exp_gnt_q[$];
  logic [1:0] exp_q[$];

  mem_island_port_mux #(
    .NumIn(4), .AddrWidth(32), .DataWidth(64), .MaxOutstanding(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_req_i(in_req_i), .in_gnt_o(in_gnt_o), .in_addr_i(in_addr_i),
    .in_we_i(in_we_i), .in_wdata_i(in_wdata_i), .in_strb_i(in_strb_i),
    .in_rvalid_o(in_rvalid_o), .in_rdata_o(in_rdata_o),
    .out_req_o(out_req_o), .out_gnt_i(out_gnt_i), .out_addr_o(out_addr_o),
    .out_we_o(out_we_o), .out_wdata_o(out_wdata_o), .out_strb_o(out_strb_o),
    .out_rvalid_i(out_rvalid_i), .out_rdata_i(out_rdata_i),
    .err_o(err_o), .dbg_locked_o(dbg_locked_o)
  );

  // Clock and watchdog
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    in_req_i     = '0;
    in_addr_i    = '0;
    in_we_i      = '0;
    in_wdata_i   = '0;
    in_strb_i    = '0;
    out_gnt_i    = 1'b0;
    out_rvalid_i = 1'b0;
    out_rdata_i  = '0;
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    clear_inputs();
    rst_i    = 1'b1;
    in_req_i = 4'hF;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i    = 1'b0;
    in_req_i = 4'h0;
    exp_gnt_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(posedge clk_i); #1;
    clear_inputs();
    rst_i     = 1'b1;
    in_req_i  = 4'hF;
    out_gnt_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      in_addr_i[0] = $urandom;
      @(negedge clk_i);
      n_tests++;
      if (out_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_out_req cyc=%0d got=%b exp=0", c, out_req_o); end
      n_tests++;
      if (in_gnt_o !== 4'h0) begin n_fail++; $display("FAIL reset_in_gnt cyc=%0d got=%b exp=0000", c, in_gnt_o); end
      n_tests++;
      if (in_rvalid_o !== 4'h0) begin n_fail++; $display("FAIL reset_in_rvalid cyc=%0d got=%b exp=0000", c, in_rvalid_o); end
      n_tests++;
      if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err cyc=%0d got=%b exp=0", c, err_o); end
      n_tests++;
      if (out_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_out_addr cyc=%0d got=%h exp=0", c, out_addr_o); end
      @(posedge clk_i); #1;
    end
    rst_i     = 1'b0;
    in_req_i  = 4'h0;
    out_gnt_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (out_req_o !== 1'b0 || err_o !== 1'b0 || dbg_locked_o !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset got req=%b err=%b locked=%b exp=0/0/0", out_req_o, err_o, dbg_locked_o);
    end
  endtask

  // All ports request, island grants always and answers one cycle later.
  task automatic test_round_robin();
    logic [1:0] e;
    logic [3:0] exp_oh;
    do_reset();
    exp_gnt_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int t = 0; t < 6; t++) begin
      @(posedge clk_i); #1;
      in_req_i     = (t < 5) ? 4'hF : 4'h0;
      for (int p = 0; p < 4; p++) in_addr_i[p] = 32'h100 * p + t;
      out_gnt_i    = (t < 5);
      out_rvalid_i = (t >= 1);
      out_rdata_i  = {$urandom, $urandom};
      @(negedge clk_i);
      if (t >= 1) begin
        e = exp_q.pop_front();
        exp_oh = 4'b0001 << e;
        n_tests++;
        if (in_rvalid_o !== exp_oh) begin n_fail++; $display("FAIL rr_rvalid cyc=%0d got=%b exp=%b", t, in_rvalid_o, exp_oh); end
        n_tests++;
        if (in_rdata_o[e] !== out_rdata_i) begin n_fail++; $display("FAIL rr_rdata cyc=%0d got=%h exp=%h", t, in_rdata_o[e], out_rdata_i); end
      end
      if (t < 5) begin
        e = exp_gnt_q.pop_front();
        exp_oh = 4'b0001 << e;
        n_tests++;
        if (in_gnt_o !== exp_oh) begin n_fail++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", t, in_gnt_o, exp_oh); end
        n_tests++;
        if (out_addr_o !== 32'h100 * e + t) begin n_fail++; $display("FAIL rr_addr cyc=%0d got=%h exp=%h", t, out_addr_o, 32'h100 * e + t); end
        exp_q.push_back(e);
      end
    end
  endtask

  // Port 2 stalls for 3 cycles; port 0 appears meanwhile but must not steal.
  task automatic test_lock();
    logic [31:0] a0;
    logic [31:0] a2;
    logic [1:0]  e;
    logic [3:0]  exp_oh;
    do_reset();
    a0 = $urandom;
    a2 = $urandom;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk_i); #1;
      in_addr_i[0] = a0;
      in_addr_i[2] = a2;
      case (t)
        0:       begin in_req_i = 4'b0100; out_gnt_i = 1'b0; out_rvalid_i = 1'b0; end
        1, 2:    begin in_req_i = 4'b0101; out_gnt_i = 1'b0; out_rvalid_i = 1'b0; end
        3:       begin in_req_i = 4'b0101; out_gnt_i = 1'b1; out_rvalid_i = 1'b0; end
        4:       begin in_req_i = 4'b0001; out_gnt_i = 1'b1; out_rvalid_i = 1'b1; end
        default: begin in_req_i = 4'b0000; out_gnt_i = 1'b0; out_rvalid_i = 1'b1; end
      endcase
      @(negedge clk_i);
      if (t <= 3) begin
        n_tests++;
        if (out_req_o !== 1'b1 || out_addr_o !== a2) begin
          n_fail++; $display("FAIL lock_addr cyc=%0d got req=%b addr=%h exp req=1 addr=%h", t, out_req_o, out_addr_o, a2);
        end
      end
      if (t == 1 || t == 2) begin
        n_tests++;
        if (in_gnt_o !== 4'b0000 || dbg_locked_o !== 1'b1) begin
          n_fail++; $display("FAIL lock_hold cyc=%0d got gnt=%b locked=%b exp gnt=0000 locked=1", t, in_gnt_o, dbg_locked_o);
        end
      end
      if (t == 3) begin
        n_tests++;
        if (in_gnt_o !== 4'b0100) begin n_fail++; $display("FAIL lock_gnt2 got=%b exp=0100", in_gnt_o); end
        exp_q.push_back(2'd2);
      end
      if (t >= 4) begin
        e = exp_q.pop_front();
        exp_oh = 4'b0001 << e;
        n_tests++;
        if (in_rvalid_o !== exp_oh) begin n_fail++; $display("FAIL lock_rvalid cyc=%0d got=%b exp=%b", t, in_rvalid_o, exp_oh); end
      end
      if (t == 4) begin
        n_tests++;
        if (in_gnt_o !== 4'b0001 || out_addr_o !== a0) begin
          n_fail++; $display("FAIL lock_wrap_gnt got gnt=%b addr=%h exp gnt=0001 addr=%h", in_gnt_o, out_addr_o, a0);
        end
        exp_q.push_back(2'd0);
      end
    end
    n_tests++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL lock_err got=%b exp=0", err_o); end
  endtask

  // Island withholds responses: exactly 4 grants, then the credit wall.
  task automatic test_credits();
    logic [1:0] e;
    logic [3:0] exp_oh;
    do_reset();
    exp_gnt_q = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int t = 0; t < 12; t++) begin
      @(posedge clk_i); #1;
      in_req_i     = (t <= 6) ? 4'hF : 4'h0;
      out_gnt_i    = (t <= 6);
      out_rvalid_i = (t == 5) || (t >= 7 && t <= 10);
      @(negedge clk_i);
      if (t <= 3) begin
        e = exp_gnt_q.pop_front();
        exp_oh = 4'b0001 << e;
        n_tests++;
        if (in_gnt_o !== exp_oh) begin n_fail++; $display("FAIL credit_gnt cyc=%0d got=%b exp=%b", t, in_gnt_o, exp_oh); end
        exp_q.push_back(e);
      end
      if (t == 4 || t == 5) begin
        n_tests++;
        if (out_req_o !== 1'b0 || in_gnt_o !== 4'b0000) begin
          n_fail++; $display("FAIL credit_full cyc=%0d got req=%b gnt=%b exp req=0 gnt=0000", t, out_req_o, in_gnt_o);
        end
      end
      if (out_rvalid_i) begin
        e = exp_q.pop_front();
        exp_oh = 4'b0001 << e;
        n_tests++;
        if (in_rvalid_o !== exp_oh) begin n_fail++; $display("FAIL credit_rvalid cyc=%0d got=%b exp=%b", t, in_rvalid_o, exp_oh); end
      end
      if (t == 6) begin
        n_tests++;
        if (out_req_o !== 1'b1 || in_gnt_o !== 4'b0001) begin
          n_fail++; $display("FAIL credit_reopen got req=%b gnt=%b exp req=1 gnt=0001", out_req_o, in_gnt_o);
        end
        exp_q.push_back(2'd0);
      end
    end
    n_tests++;
    if (err_o !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL credit_drain got err=%b left=%0d exp err=0 left=0", err_o, exp_q.size());
    end
  endtask

  // Port 1 writes, port 3 reads the same word back through a one-word island model.
  task automatic test_mixed_rw();
    logic [63:0] island_word;
    island_word = '0;
    do_reset();
    // cycle 0: write from port 1
    @(posedge clk_i); #1;
    in_req_i      = 4'b0010;
    in_we_i       = 4'b0010;
    in_addr_i[1]  = 32'h40;
    in_wdata_i[1] = 64'hDEAD_BEEF;
    in_strb_i[1]  = 8'hFF;
    out_gnt_i     = 1'b1;
    island_word   = 64'hDEAD_BEEF;
    @(negedge clk_i);
    n_tests++;
    if (in_gnt_o !== 4'b0010 || out_we_o !== 1'b1 || out_addr_o !== 32'h40 ||
        out_wdata_o !== 64'hDEAD_BEEF || out_strb_o !== 8'hFF) begin
      n_fail++;
      $display("FAIL mixed_write got gnt=%b we=%b addr=%h wdata=%h strb=%h exp 0010/1/40/deadbeef/ff",
               in_gnt_o, out_we_o, out_addr_o, out_wdata_o, out_strb_o);
    end
    exp_q.push_back(2'd1);
    // cycle 1: read from port 3, write acknowledged
    @(posedge clk_i); #1;
    in_req_i     = 4'b1000;
    in_we_i      = 4'b0000;
    in_addr_i[3] = 32'h40;
    out_rvalid_i = 1'b1;
    out_rdata_i  = '0;
    @(negedge clk_i);
    n_tests++;
    if (in_gnt_o !== 4'b1000 || out_we_o !== 1'b0 || out_addr_o !== 32'h40) begin
      n_fail++; $display("FAIL mixed_read_req got gnt=%b we=%b addr=%h exp 1000/0/40", in_gnt_o, out_we_o, out_addr_o);
    end
    n_tests++;
    if (in_rvalid_o !== (4'b0001 << exp_q.pop_front())) begin
      n_fail++; $display("FAIL mixed_write_ack got=%b exp=0010", in_rvalid_o);
    end
    exp_q.push_back(2'd3);
    // cycle 2: read data returns
    @(posedge clk_i); #1;
    in_req_i     = 4'b0000;
    out_gnt_i    = 1'b0;
    out_rvalid_i = 1'b1;
    out_rdata_i  = island_word;
    @(negedge clk_i);
    n_tests++;
    if (in_rvalid_o !== (4'b0001 << exp_q.pop_front()) || in_rdata_o[3] !== 64'hDEAD_BEEF) begin
      n_fail++; $display("FAIL mixed_read_rsp got rvalid=%b rdata=%h exp 1000/deadbeef", in_rvalid_o, in_rdata_o[3]);
    end
    @(posedge clk_i); #1;
    out_rvalid_i = 1'b0;
  endtask

  // Spurious response, dropped locked request, and a response after reset.
  task automatic test_errors();
    do_reset();
    @(posedge clk_i); #1;
    out_rvalid_i = 1'b1;
    out_rdata_i  = {$urandom, $urandom};
    @(negedge clk_i);
    n_tests++;
    if (in_rvalid_o !== 4'b0000 || err_o !== 1'b0) begin
      n_fail++; $display("FAIL err_spurious_same got rvalid=%b err=%b exp 0000/0", in_rvalid_o, err_o);
    end
    for (int t = 0; t < 3; t++) begin
      @(posedge clk_i); #1;
      out_rvalid_i = 1'b0;
      @(negedge clk_i);
      n_tests++;
      if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_sticky cyc=%0d got=%b exp=1", t, err_o); end
    end
    do_reset();
    @(negedge clk_i);
    n_tests++;
    if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_cleared got=%b exp=0", err_o); end

    // Locked request dropped before grant.
    @(posedge clk_i); #1;
    in_req_i  = 4'b0100;
    out_gnt_i = 1'b0;
    @(posedge clk_i); #1;
    in_req_i  = 4'b0000;
    @(negedge clk_i);
    n_tests++;
    if (err_o !== 1'b0 || dbg_locked_o !== 1'b1) begin
      n_fail++; $display("FAIL err_drop_same got err=%b locked=%b exp 0/1", err_o, dbg_locked_o);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    n_tests++;
    if (err_o !== 1'b1 || dbg_locked_o !== 1'b0) begin
      n_fail++; $display("FAIL err_drop got err=%b locked=%b exp 1/0", err_o, dbg_locked_o);
    end

    // Outstanding request discarded by reset; its late response is an error.
    do_reset();
    @(posedge clk_i); #1;
    in_req_i  = 4'b0010;
    out_gnt_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (in_gnt_o !== 4'b0010) begin n_fail++; $display("FAIL err_pre_gnt got=%b exp=0010", in_gnt_o); end
    do_reset();
    @(posedge clk_i); #1;
    out_rvalid_i = 1'b1;
    @(negedge clk_i);
    n_tests++;
    if (in_rvalid_o !== 4'b0000) begin n_fail++; $display("FAIL err_stale_rvalid got=%b exp=0000", in_rvalid_o); end
    @(posedge clk_i); #1;
    out_rvalid_i = 1'b0;
    @(negedge clk_i);
    n_tests++;
    if (err_o !== 1'b1) begin n_fail++; $display("FAIL err_stale got=%b exp=1", err_o); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_i   = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_lock();
    test_credits();
    test_mixed_rw();
    test_errors();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
